// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hazState_e        : controller FSM states (normal run / waiting on the multi-cycle unit)
//   DefaultMultCycles : default EX-stage multiply latency in cycles
//   DefaultDivCycles  : default EX-stage divide latency in cycles
//   CntWidth          : width of the multi-cycle down-counter
package hazard_controller_pkg;

  typedef enum logic [0:0] {
    Run     = 1'b0,
    MduWait = 1'b1
  } hazState_e;

  localparam int unsigned DefaultMultCycles = 4;
  localparam int unsigned DefaultDivCycles  = 32;
  localparam int unsigned CntWidth          = 6;

endpackage

// File: rtl/mdu_cycle_counter.sv
// Down-counter that times a multi-cycle multiply/divide.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load loadValue (has priority over decrement)
//   loadValue  : value to load
//   decrement  : count down by one; saturates at zero
//   count      : current count
//   isZero     : count == 0
module mdu_cycle_counter
  import hazard_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CntWidth-1:0] loadValue,
  input  logic                decrement,
  output logic [CntWidth-1:0] count,
  output logic                isZero
);

  logic [CntWidth-1:0] cntQ, cntD;

  always_comb begin
    cntD = cntQ;
    if (load) begin
      cntD = loadValue;
    end else if (decrement && (cntQ != '0)) begin
      cntD = cntQ - CntWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign count  = cntQ;
  assign isZero = (cntQ == '0);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze and
// multi-cycle multiply/divide stall for a 5-stage pipeline.
//   Inputs : IdExMemRead/IdExRegRt (load in EX), IfIdRegRs/IfIdRegRt (ID sources),
//            BranchTaken, MduStart/MduIsDiv, ExMemMemAccess/MemReady.
//   Outputs: PcWrite, IfIdWrite, IdExWrite, ExMemWrite (register enables),
//            IfIdFlush, IdExFlush, ExMemFlush, MemWbFlush (bubble insertion),
//            MduBusy (op in progress), MduDone (one-cycle registered completion pulse).
// Enables/flushes are combinational from state and inputs.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DefaultMultCycles,
  parameter int unsigned DIV_CYCLES  = DefaultDivCycles
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IdExMemRead,
  input  logic [4:0] IdExRegRt,
  input  logic [4:0] IfIdRegRs,
  input  logic [4:0] IfIdRegRt,
  input  logic       BranchTaken,
  input  logic       MduStart,
  input  logic       MduIsDiv,
  input  logic       ExMemMemAccess,
  input  logic       MemReady,
  output logic       PcWrite,
  output logic       IfIdWrite,
  output logic       IdExWrite,
  output logic       ExMemWrite,
  output logic       IfIdFlush,
  output logic       IdExFlush,
  output logic       ExMemFlush,
  output logic       MemWbFlush,
  output logic       MduBusy,
  output logic       MduDone
);

  // The start cycle counts as one, and the counter's zero cycle is the last
  // busy cycle, so a latency of N loads N-2.
  localparam logic [CntWidth-1:0] MultLoad = CntWidth'(MULT_CYCLES - 2);
  localparam logic [CntWidth-1:0] DivLoad  = CntWidth'(DIV_CYCLES - 2);

  hazState_e           stateQ, stateD;
  logic                doneQ, doneD;
  logic                memFreeze, loadUse;
  logic                cntLoad, cntZero;
  logic [CntWidth-1:0] cntLoadValue, cntValue;

  assign memFreeze = ExMemMemAccess & ~MemReady;
  assign loadUse   = IdExMemRead & (IdExRegRt != 5'd0) &
                     ((IdExRegRt == IfIdRegRs) | (IdExRegRt == IfIdRegRt));

  mdu_cycle_counter u_mdu_cycle_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .decrement (stateQ == MduWait),
    .count     (cntValue),
    .isZero    (cntZero)
  );

  // Next-state logic
  always_comb begin
    stateD       = stateQ;
    doneD        = 1'b0;
    cntLoad      = 1'b0;
    cntLoadValue = MduIsDiv ? DivLoad : MultLoad;
    unique case (stateQ)
      Run: begin
        if (MduStart && !memFreeze) begin
          cntLoad = 1'b1;
          stateD  = MduWait;
        end
      end
      MduWait: begin
        // A freeze at count zero holds the op until memory completes.
        if (cntZero && !memFreeze) begin
          doneD  = 1'b1;
          stateD = Run;
        end
      end
      default: stateD = Run;
    endcase
  end

  // Pipeline control outputs, highest-priority condition first
  always_comb begin
    PcWrite    = 1'b1;
    IfIdWrite  = 1'b1;
    IdExWrite  = 1'b1;
    ExMemWrite = 1'b1;
    IfIdFlush  = 1'b0;
    IdExFlush  = 1'b0;
    ExMemFlush = 1'b0;
    MemWbFlush = 1'b0;
    if (!rst_n) begin
      // Hold the pipeline in its pass-through configuration while in reset.
    end else if (memFreeze) begin
      PcWrite    = 1'b0;
      IfIdWrite  = 1'b0;
      IdExWrite  = 1'b0;
      ExMemWrite = 1'b0;
      MemWbFlush = 1'b1;
    end else if (stateQ == MduWait) begin
      PcWrite    = 1'b0;
      IfIdWrite  = 1'b0;
      IdExWrite  = 1'b0;
      ExMemFlush = 1'b1;
    end else if (loadUse) begin
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
      IdExFlush = 1'b1;
    end else if (BranchTaken) begin
      IfIdFlush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= Run;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      doneQ  <= doneD;
    end
  end

  assign MduBusy = (stateQ == MduWait);
  assign MduDone = doneQ;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter MULT_CYCLES, default 4, EX-stage multiply latency in cycles (range 2..63).
REQ-002 Parameter DIV_CYCLES, default 32, EX-stage divide latency in cycles (range 2..63).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 IdExMemRead  in  1  instruction in EX is a load.
REQ-006 IdExRegRt  in  5  load destination register in EX.
REQ-007 IfIdRegRs, IfIdRegRt  in  5 each  source registers of the instruction in ID.
REQ-008 BranchTaken  in  1  branch/jump resolved taken in ID this cycle.
REQ-009 MduStart  in  1  mult/div instruction entering EX this cycle; MduIsDiv  in  1  selects divide.
REQ-010 ExMemMemAccess  in  1  load/store in MEM; MemReady  in  1  data memory completes this cycle.
REQ-011 PcWrite, IfIdWrite, IdExWrite, ExMemWrite  out  1 each  pipeline-register enables.
REQ-012 IfIdFlush, IdExFlush, ExMemFlush, MemWbFlush  out  1 each  bubble insertion into that register.
REQ-013 MduBusy  out  1  multicycle op in progress; MduDone  out  1  one-cycle completion pulse.

Function
REQ-014 Condition MemFreeze = ExMemMemAccess & ~MemReady; Hazard = IdExMemRead & IdExRegRt!=0 & (IdExRegRt==IfIdRegRs | IdExRegRt==IfIdRegRt).
REQ-015 FSM states: RUN, MDU_WAIT; 6-bit down-counter Cnt.
REQ-016 Priority per cycle: MemFreeze > MDU_WAIT > load-use Hazard > BranchTaken.
REQ-017 MemFreeze (any state): all four write enables 0, MemWbFlush 1, all other flushes 0.
REQ-018 MDU_WAIT without MemFreeze: PcWrite, IfIdWrite, IdExWrite 0; ExMemWrite 1; ExMemFlush 1.
REQ-019 RUN with Hazard: PcWrite 0, IfIdWrite 0, IdExFlush 1 for exactly one cycle; BranchTaken ignored that cycle.
REQ-020 RUN with BranchTaken and no Hazard: IfIdFlush 1; all enables 1.
REQ-021 RUN, no event: all enables 1, all flushes 0.
REQ-022 RUN, MduStart 1, no MemFreeze: Cnt <= (MduIsDiv ? DIV_CYCLES : MULT_CYCLES) - 2, next state MDU_WAIT.
REQ-023 MduStart sampled only in RUN without MemFreeze; ignored otherwise.
REQ-024 MDU_WAIT: Cnt decrements each cycle while Cnt!=0, including during MemFreeze.
REQ-025 MDU_WAIT, Cnt==0, no MemFreeze: MduDone 1 (registered, asserted the following cycle), next state RUN.
REQ-026 MDU_WAIT, Cnt==0, MemFreeze: remain in MDU_WAIT; completion deferred until MemFreeze clears.
REQ-027 MduBusy = (state==MDU_WAIT); total stall = configured cycles - 1 after the MduStart cycle.
REQ-028 Write-enable/flush outputs are combinational from state and inputs; no input-to-output latch.

Reset
REQ-029 rst_n low asynchronously forces state RUN, Cnt 0, MduDone 0.
REQ-030 During reset: all write enables 1, all flushes 0, MduBusy 0.
REQ-031 Reset mid-MDU_WAIT aborts the operation; no MduDone pulse is produced.

Structure
REQ-032 Shared package holds the state enum (RUN, MDU_WAIT) and default cycle constants.
REQ-033 One sub-module, mdu_cycle_counter (load, decrement, zero flag), is instantiated.

Verification
REQ-034 Load into $t0 in EX, ID reads $t0 as Rs -> one cycle PcWrite=0, IfIdWrite=0, IdExFlush=1, then normal.
REQ-035 Load into $zero with ID reading $zero -> no stall.
REQ-036 MduStart, MduIsDiv=1, default params -> MduBusy 31 cycles, MduDone pulse once, PC frozen throughout.
REQ-037 ExMemMemAccess=1, MemReady=0 for 3 cycles during a multiply -> all enables 0 for 3 cycles; MduDone delayed until freeze ends.
REQ-038 Hazard and BranchTaken same cycle -> only load-use stall; branch flush occurs the next cycle.
REQ-039 rst_n low at divide cycle 10 -> immediate RUN, MduBusy 0, no MduDone after release.
